// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and stage bundle widths for elastic pipeline registers
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int IF_ID_W = 64;
  localparam int ID_EX_W = 166;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_HALF  = ST_HALF,
    S_FULL  = ST_FULL
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - handshake bundle between a pipeline register and its neighbours
interface pipe_skid_reg_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] stall_count;

  // The register itself: consumes upstream/hazard controls, produces the staged bundle.
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, stall_count
  );

  // Surrounding pipeline: presents bundles, stall and squash controls.
  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, stall_count
  );

endinterface

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - elastic pipeline register with one-entry skid, flush and stall counter
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic           clk,
  input  logic           reset,
  pipe_skid_reg_if.slave bus
);

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_skid_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;

  // in_ready is decoded from state only, so stalls never ripple upstream combinationally.
  assign w_in_ready  = (r_state != S_FULL);
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_data    = w_out_valid ? r_main : NOP_VALUE;
  assign bus.stall_count = r_stall_cnt;

  // State and data registers; everything returns to NOP/EMPTY on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_main  <= NOP_VALUE;
      r_skid  <= NOP_VALUE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Next-state and data steering; flush wins over every handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = NOP_VALUE;
      w_skid_nxt  = NOP_VALUE;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_HALF;
            w_main_nxt  = bus.in_data;
          end
        end
        S_HALF: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = bus.in_data;
          end else if (w_in_fire) begin
            // Downstream stalled: park the in-flight bundle behind main.
            w_state_nxt = S_FULL;
            w_skid_nxt  = bus.in_data;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = NOP_VALUE;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = S_HALF;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_main_nxt  = NOP_VALUE;
          w_skid_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  // Saturating count of cycles where a live bundle waits on downstream, flush cycles included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam logic [7:0] NOP = 8'hE0;

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [15:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.WIDTH(8), .CNT_W(16)) b8 ();
  pipe_skid_reg_if #(.WIDTH(8), .CNT_W(4))  b4 ();

  pipe_skid_reg #(.WIDTH(8), .NOP_VALUE(NOP), .CNT_W(16)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8.slave)
  );

  pipe_skid_reg #(.WIDTH(8), .NOP_VALUE(NOP), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4.slave)
  );

  assign b4.in_valid  = b8.in_valid;
  assign b4.in_data   = b8.in_data;
  assign b4.out_ready = b8.out_ready;
  assign b4.flush     = b8.flush;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: bundles accepted by the model, oldest at the front.
  logic [7:0] m_q[$];
  int m_cnt16 = 0;
  int m_cnt4  = 0;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    b8.in_valid  = iv;
    b8.in_data   = d;
    b8.out_ready = ordy;
    b8.flush     = fl;
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                     input logic e_ir, input logic e_ov, input logic [7:0] e_od, input logic [15:0] e_cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_od;
    exp_od = (m_q.size() != 0) ? m_q[0] : NOP;
    chk({tag, ".in_ready"},  32'(b8.in_ready),    32'(m_q.size() < 2));
    chk({tag, ".out_valid"}, 32'(b8.out_valid),   32'(m_q.size() != 0));
    chk({tag, ".out_data"},  32'(b8.out_data),    32'(exp_od));
    chk({tag, ".cnt16"},     32'(b8.stall_count), 32'(m_cnt16));
    chk({tag, ".cnt4"},      32'(b4.stall_count), 32'(m_cnt4));
  endtask

  // Advance the model across the coming edge using the inputs currently driven.
  task automatic model_step();
    logic m_ir, m_ov, in_fire, out_fire;
    m_ir     = (m_q.size() < 2);
    m_ov     = (m_q.size() != 0);
    in_fire  = b8.in_valid && m_ir;
    out_fire = m_ov && b8.out_ready;
    if (m_ov && !b8.out_ready) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15)     m_cnt4++;
    end
    if (out_fire) void'(m_q.pop_front());
    if (b8.flush) m_q.delete();
    else if (in_fire) m_q.push_back(b8.in_data);
  endtask

  task automatic tail(input string tag);
    check_model(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    tail(tag);
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 8'h00, 1'b0, 1'b0);

    // Streaming 0x01..0x08 with out_ready held high.
    for (int i = 1; i <= 8; i++)
      add(1'b1, 8'(i), 1'b1, 1'b0, 1'b1, (i != 1), (i == 1) ? NOP : 8'(i - 1), 16'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h08, 16'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, NOP,   16'd0);
    // Skid fill with A/B, then drain.
    add(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, NOP,   16'd0);
    add(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 16'd0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 16'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 16'd2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBB, 16'd2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, NOP,   16'd2);
    // Flush while FULL with 0xCC offered.
    add(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, NOP,   16'd2);
    add(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 16'd2);
    add(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 16'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, NOP,   16'd4);
    // Flush in HALF with out_ready: 0x33 delivered, 0x44 dropped.
    add(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, NOP,   16'd4);
    add(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 16'd4);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, NOP,   16'd4);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, NOP,   16'd4);

    #2;
    chk("rst.in_ready",  32'(b8.in_ready),    32'd1);
    chk("rst.out_valid", 32'(b8.out_valid),   32'd0);
    chk("rst.out_data",  32'(b8.out_data),    32'(NOP));
    chk("rst.cnt",       32'(b8.stall_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      set_in(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      @(negedge clk);
      chk({tag, ".e_in_ready"},  32'(b8.in_ready),    32'(tbl[i].e_ir));
      chk({tag, ".e_out_valid"}, 32'(b8.out_valid),   32'(tbl[i].e_ov));
      chk({tag, ".e_out_data"},  32'(b8.out_data),    32'(tbl[i].e_od));
      chk({tag, ".e_cnt"},       32'(b8.stall_count), 32'(tbl[i].e_cnt));
      tail(tag);
    end

    // Counter saturation on the 4-bit instance: 20 stalled-valid cycles.
    set_in(1'b1, 8'h77, 1'b0, 1'b0);
    cycle("sat.load");
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (20) cycle("sat.stall");
    @(negedge clk);
    chk("sat.cnt4_is_15", 32'(b4.stall_count), 32'd15);
    chk("sat.cnt16_is_24", 32'(b8.stall_count), 32'd24);
    tail("sat.end");
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    cycle("sat.drain");
    cycle("sat.idle");

    // Asynchronous reset between edges while FULL.
    set_in(1'b1, 8'h66, 1'b0, 1'b0);
    cycle("ar.a");
    set_in(1'b1, 8'h99, 1'b0, 1'b0);
    cycle("ar.b");
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ar.pre_in_ready", 32'(b8.in_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar.in_ready",  32'(b8.in_ready),    32'd1);
    chk("ar.out_valid", 32'(b8.out_valid),   32'd0);
    chk("ar.out_data",  32'(b8.out_data),    32'(NOP));
    chk("ar.cnt16",     32'(b8.stall_count), 32'd0);
    chk("ar.cnt4",      32'(b4.stall_count), 32'd0);
    reset = 1'b0;
    m_q.delete();
    m_cnt16 = 0;
    m_cnt4  = 0;
    set_in(1'b1, 8'h55, 1'b1, 1'b0);
    cycle("ar.send55");
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("ar.out55_valid", 32'(b8.out_valid), 32'd1);
    chk("ar.out55_data",  32'(b8.out_data),  32'h55);
    tail("ar.out55");
    cycle("ar.idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
